// File: rtl/robot_cmd_sequencer.sv
// Command recorder/player for the robot demo: stores 2-bit motion commands,
// then replays them in order through a valid/ready handshake with a fixed dwell per command.
module robot_cmd_sequencer #(
    parameter int DEPTH        = 256,
    parameter int ADDR_W       = 8,
    parameter int DWELL_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cmd_in,
    input  logic              save_pulse,
    input  logic              exec_pulse,
    input  logic              clear_pulse,
    output logic [1:0]        step_cmd,
    output logic              step_valid,
    input  logic              step_ready,
    output logic [1:0]        active_cmd,
    output logic              active,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] step_idx,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              error
);

    localparam int                DW_W       = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW_W-1:0]   DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C      = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_PROGRAM,
        S_FETCH,
        S_ISSUE,
        S_DWELL,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_mem [DEPTH];
    logic [1:0]        r_rd_data;
    logic [1:0]        r_active_cmd;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_step_idx;
    logic [DW_W-1:0]   r_dwell;
    logic              r_error;

    logic              w_we;
    logic              w_start;
    logic              w_accept;
    logic              w_advance;
    logic              w_reject;
    logic              w_full;
    logic              w_last;
    logic              w_busy_req;
    logic [ADDR_W-1:0] w_addr;

    assign w_full     = (r_count == DEPTH_C);
    assign w_last     = ({1'b0, r_step_idx} == (r_count - ONE_C));
    assign w_busy_req = save_pulse | exec_pulse;
    // The single RAM port writes at the append position and otherwise reads the playback entry.
    assign w_addr     = w_we ? r_count[ADDR_W-1:0] : r_step_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_PROGRAM;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next    = r_state;
        w_we      = 1'b0;
        w_start   = 1'b0;
        w_accept  = 1'b0;
        w_advance = 1'b0;
        w_reject  = 1'b0;
        if (clear_pulse) begin
            w_next = S_PROGRAM;
        end else begin
            case (r_state)
                S_PROGRAM, S_DONE: begin
                    if (exec_pulse) begin
                        if (r_count != '0) begin
                            w_start = 1'b1;
                            w_next  = S_FETCH;
                        end else begin
                            w_reject = 1'b1;
                        end
                    end else if (save_pulse) begin
                        if (!w_full) begin
                            w_we   = 1'b1;
                            w_next = S_PROGRAM;
                        end else begin
                            w_reject = 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    w_reject = w_busy_req;
                    w_next   = S_ISSUE;
                end
                S_ISSUE: begin
                    w_reject = w_busy_req;
                    if (step_ready) begin
                        w_accept = 1'b1;
                        w_next   = S_DWELL;
                    end
                end
                S_DWELL: begin
                    w_reject = w_busy_req;
                    if (r_dwell == '0) begin
                        if (w_last) begin
                            w_next = S_DONE;
                        end else begin
                            w_advance = 1'b1;
                            w_next    = S_FETCH;
                        end
                    end
                end
                default: w_next = S_PROGRAM;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count      <= '0;
            r_step_idx   <= '0;
            r_dwell      <= '0;
            r_active_cmd <= 2'b00;
            r_error      <= 1'b0;
        end else begin
            r_error <= w_reject;
            if (clear_pulse) begin
                r_count    <= '0;
                r_step_idx <= '0;
            end else begin
                if (w_we) begin
                    r_count <= r_count + ONE_C;
                end
                if (w_start) begin
                    r_step_idx <= '0;
                end else if (w_advance) begin
                    r_step_idx <= r_step_idx + 1'b1;
                end
                if (w_accept) begin
                    r_active_cmd <= r_rd_data;
                    r_dwell      <= DWELL_LOAD;
                end else if (r_state == S_DWELL) begin
                    r_dwell <= r_dwell - 1'b1;
                end
            end
        end
    end

    // NOTE: the command buffer has no reset so it maps onto block RAM; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_addr] <= cmd_in;
        end
        r_rd_data <= r_mem[w_addr];
    end

    assign step_valid = (r_state == S_ISSUE);
    assign step_cmd   = step_valid ? r_rd_data : 2'b00;
    assign active     = (r_state == S_DWELL);
    assign active_cmd = r_active_cmd;
    assign busy       = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_DWELL);
    assign done       = (r_state == S_DONE);
    assign full       = w_full;
    assign error      = r_error;
    assign count      = r_count;
    assign step_idx   = r_step_idx;

endmodule

// File: tb/tb_robot_cmd_sequencer.sv
// Bench for robot_cmd_sequencer: a table of single-cycle programming vectors, directed
// multi-cycle scenarios, and randomized record/playback checked against a queue model.
module tb_robot_cmd_sequencer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int DWELL  = 4;

    logic              clk;
    logic              rst;
    logic [1:0]        cmd_in;
    logic              save_pulse;
    logic              exec_pulse;
    logic              clear_pulse;
    logic [1:0]        step_cmd;
    logic              step_valid;
    logic              step_ready;
    logic [1:0]        active_cmd;
    logic              active;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] step_idx;
    logic              busy;
    logic              done;
    logic              full;
    logic              error;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the ordered list of commands the buffer should hold.
    logic [1:0] exp_q[$];

    typedef struct {
        logic [1:0]      cmd;
        logic            save;
        logic            exec;
        logic            clear;
        logic [ADDR_W:0] exp_count;
        logic            exp_full;
        logic            exp_error;
    } vec_t;

    vec_t vecs[11];

    robot_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .DWELL_CYCLES(DWELL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_in     (cmd_in),
        .save_pulse (save_pulse),
        .exec_pulse (exec_pulse),
        .clear_pulse(clear_pulse),
        .step_cmd   (step_cmd),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .active_cmd (active_cmd),
        .active     (active),
        .count      (count),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done),
        .full       (full),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change just after a falling edge; outputs are sampled at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear_pulse = 1'b1;
        step();
        clear_pulse = 1'b0;
        exp_q.delete();
        check("clear_count", 32'(count), 0);
        check("clear_busy", 32'(busy), 0);
        check("clear_done", 32'(done), 0);
        check("clear_valid", 32'(step_valid), 0);
        check("clear_active", 32'(active), 0);
    endtask

    task automatic record(input logic [1:0] c);
        logic exp_err;
        logic done_before;
        exp_err     = (exp_q.size() == DEPTH);
        done_before = done;
        cmd_in      = c;
        save_pulse  = 1'b1;
        step();
        save_pulse  = 1'b0;
        if (!exp_err) exp_q.push_back(c);
        check("save_error", 32'(error), 32'(exp_err));
        check("save_count", 32'(count), exp_q.size());
        check("save_full", 32'(full), 32'(exp_q.size() == DEPTH));
        check("save_done", 32'(done), exp_err ? 32'(done_before) : 32'd0);
        check("save_busy", 32'(busy), 0);
    endtask

    // Starts playback and follows it to DONE, checking order, dwell length,
    // handshake-to-active latency and step_cmd stability under backpressure.
    task automatic play_and_check(input int stall, input int pct, input bit timed);
        int         n;
        int         cyc;
        int         idx;
        int         act_left;
        int         stalled;
        int         budget;
        bit         hs;
        bit         prev_valid;
        bit         prev_hs;
        bit         finished;
        logic [1:0] prev_cmd;
        n          = exp_q.size();
        budget     = n * (DWELL + 2 + 60) + stall + 10;
        idx        = 0;
        act_left   = 0;
        stalled    = 0;
        hs         = 1'b0;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        finished   = 1'b0;
        prev_cmd   = 2'b00;
        exec_pulse = 1'b1;
        step();
        exec_pulse = 1'b0;
        cyc        = 1;
        while (!finished && cyc <= budget) begin
            if (hs) begin
                check("play_active_rise", 32'(active), 1);
                if (idx < n) check("play_active_cmd", 32'(active_cmd), 32'(exp_q[idx]));
                idx++;
                act_left = DWELL - 1;
            end else if (act_left > 0) begin
                check("play_active_hold", 32'(active), 1);
                check("play_active_cmd_hold", 32'(active_cmd), 32'(exp_q[idx-1]));
                act_left--;
            end else begin
                check("play_active_low", 32'(active), 0);
            end
            if (done) begin
                finished = 1'b1;
                check("play_issued", idx, n);
                check("play_end_idx", 32'(step_idx), n - 1);
                check("play_end_busy", 32'(busy), 0);
                check("play_end_valid", 32'(step_valid), 0);
                check("play_end_error", 32'(error), 0);
                if (timed) check("play_cycles", cyc, n * (DWELL + 2) + 1);
            end else begin
                check("play_busy", 32'(busy), 1);
                check("play_error", 32'(error), 0);
                if (step_valid) begin
                    if (idx < n) begin
                        check("play_step_cmd", 32'(step_cmd), 32'(exp_q[idx]));
                        check("play_step_idx", 32'(step_idx), idx);
                    end else begin
                        check("play_extra_cmd", 32'(step_valid), 0);
                    end
                    if (prev_valid && !prev_hs) check("play_cmd_stable", 32'(step_cmd), 32'(prev_cmd));
                end
                prev_valid = step_valid;
                prev_cmd   = step_cmd;
                if (step_valid && stalled < stall) begin
                    step_ready = 1'b0;
                    stalled++;
                end else begin
                    step_ready = ($urandom_range(1, 100) <= pct);
                end
                hs      = step_valid && step_ready;
                prev_hs = hs;
                step();
                cyc++;
            end
        end
        if (!finished) check("play_timeout", 32'(done), 1);
    endtask

    initial begin
        rst         = 1'b1;
        cmd_in      = 2'b00;
        save_pulse  = 1'b0;
        exec_pulse  = 1'b0;
        clear_pulse = 1'b0;
        step_ready  = 1'b1;

        vecs[0]  = '{2'b00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};  // exec on empty buffer
        vecs[1]  = '{2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{2'b00, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[4]  = '{2'b11, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[5]  = '{2'b10, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0};
        vecs[6]  = '{2'b01, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};  // save when full
        vecs[7]  = '{2'b00, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0};
        vecs[8]  = '{2'b00, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};  // clear wins over exec and save
        vecs[9]  = '{2'b10, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{2'b00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};

        #1;
        check("rst_count", 32'(count), 0);
        check("rst_step_idx", 32'(step_idx), 0);
        check("rst_valid", 32'(step_valid), 0);
        check("rst_active", 32'(active), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_active_cmd", 32'(active_cmd), 0);
        check("rst_step_cmd", 32'(step_cmd), 0);
        check("rst_full", 32'(full), 0);
        step();
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            cmd_in      = vecs[i].cmd;
            save_pulse  = vecs[i].save;
            exec_pulse  = vecs[i].exec;
            clear_pulse = vecs[i].clear;
            step();
            save_pulse  = 1'b0;
            exec_pulse  = 1'b0;
            clear_pulse = 1'b0;
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
            check($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].exp_error));
            check($sformatf("vec%0d_busy", i), 32'(busy), 0);
            check($sformatf("vec%0d_valid", i), 32'(step_valid), 0);
            check($sformatf("vec%0d_done", i), 32'(done), 0);
        end
        step();
        check("vec_error_one_cycle", 32'(error), 0);

        // Record and play with step_ready held high.
        exp_q.delete();
        record(2'b00);
        record(2'b01);
        record(2'b11);
        play_and_check(0, 100, 1'b1);
        step();
        step();
        check("done_held", 32'(done), 1);
        check("done_idle_busy", 32'(busy), 0);

        // Backpressure: replay from DONE with step_ready low for the first 10 ISSUE cycles.
        play_and_check(10, 100, 1'b0);

        // Capacity: fifth save is rejected, playback emits four commands.
        pulse_clear();
        record(2'b10);
        record(2'b11);
        record(2'b00);
        record(2'b01);
        record(2'b11);
        play_and_check(0, 100, 1'b1);

        // Misuse while busy, then abort during the dwell of step 1.
        pulse_clear();
        record(2'b00);
        record(2'b01);
        record(2'b11);
        step_ready = 1'b1;
        exec_pulse = 1'b1;
        step();
        exec_pulse = 1'b0;
        for (int k = 0; k < 40 && !(active && step_idx == 1); k++) step();
        check("abort_reach_dwell1", 32'(active && step_idx == 1), 1);
        cmd_in     = 2'b10;
        save_pulse = 1'b1;
        step();
        save_pulse = 1'b0;
        check("busy_save_error", 32'(error), 1);
        check("busy_save_count", 32'(count), 3);
        check("busy_save_active", 32'(active), 1);
        exec_pulse = 1'b1;
        step();
        exec_pulse = 1'b0;
        check("busy_exec_error", 32'(error), 1);
        check("busy_exec_busy", 32'(busy), 1);
        pulse_clear();
        check("abort_step_idx", 32'(step_idx), 0);
        check("abort_error", 32'(error), 0);
        exec_pulse = 1'b1;
        step();
        exec_pulse = 1'b0;
        check("abort_exec_error", 32'(error), 1);
        check("abort_exec_busy", 32'(busy), 0);

        // Asynchronous reset while a command is waiting in ISSUE.
        record(2'b00);
        record(2'b01);
        step_ready = 1'b0;
        exec_pulse = 1'b1;
        step();
        exec_pulse = 1'b0;
        for (int k = 0; k < 10 && !step_valid; k++) step();
        check("arst_reach_issue", 32'(step_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(step_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_active", 32'(active), 0);
        check("arst_step_cmd", 32'(step_cmd), 0);
        check("arst_step_idx", 32'(step_idx), 0);
        check("arst_done", 32'(done), 0);
        check("arst_error", 32'(error), 0);
        step();
        rst = 1'b0;
        step();
        exp_q.delete();
        record(2'b10);
        play_and_check(0, 100, 1'b1);

        // Randomized record/playback against the queue model.
        for (int it = 0; it < 8; it++) begin
            int n;
            pulse_clear();
            n = $urandom_range(1, DEPTH + 2);
            for (int j = 0; j < n; j++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) step();
                record(2'($urandom_range(0, 3)));
            end
            play_and_check($urandom_range(0, 5), $urandom_range(30, 100), 1'b0);
            if ($urandom_range(0, 1) == 1) play_and_check(0, $urandom_range(50, 100), 1'b0);
            if (exp_q.size() < DEPTH) begin
                record(2'($urandom_range(0, 3)));
                play_and_check(0, 100, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/robot_cmd_sequencer.md
Name: robot_cmd_sequencer

Overview:
- Records 2-bit motion commands (00 fwd, 01 right, 10 left, 11 back) into an internal command buffer.
- On request, plays the commands back in order. Each command goes to the downstream display/LED decoder through a valid/ready handshake and is then held for a fixed dwell time.
- Sits between the board key/switch front end (debounced, single-cycle pulses) and the HEX/LEDR decoder.

Parameters:
- DEPTH, 256, command buffer entries.
- ADDR_W, 8, log2(DEPTH).
- DWELL_CYCLES, 100000000, clocks each command stays active (2 s at 50 MHz). Must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_in  in  2  command to record (from SW[1:0])
- save_pulse  in  1  one-cycle pulse: append cmd_in
- exec_pulse  in  1  one-cycle pulse: start playback
- clear_pulse  in  1  one-cycle pulse: abort and empty the buffer
- step_cmd  out  2  command offered downstream
- step_valid  out  1  step_cmd is valid
- step_ready  in  1  downstream accepts step_cmd
- active_cmd  out  2  command currently being executed
- active  out  1  high during dwell of active_cmd
- count  out  ADDR_W+1  number of stored commands
- step_idx  out  ADDR_W  index of current playback entry
- busy  out  1  playback in progress (FETCH/ISSUE/DWELL)
- done  out  1  playback complete; held high until next exec or clear
- full  out  1  count==DEPTH
- error  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (async, any state):
  - state=PROGRAM.
  - count=0, step_idx=0.
  - step_valid=0, active=0, done=0, error=0, busy=0.
  - active_cmd=00, step_cmd=00.
  - Buffer contents are don't-care.
- Buffer: single-port synchronous RAM, 1-cycle read latency; write data at address count.
- States: PROGRAM, FETCH, ISSUE, DWELL, DONE.
- Priority when pulses coincide in the same cycle: clear > exec > save.
- PROGRAM state:
  - save with !full: write cmd_in at address count; count+1 on the next cycle.
  - save with full: no write, error pulse.
  - exec with count>0: step_idx=0, done=0, go to FETCH.
  - exec with count==0: error pulse, stay in PROGRAM.
- FETCH state: present RAM address step_idx; go to ISSUE the next cycle.
- ISSUE state:
  - step_valid=1, step_cmd=RAM data.
  - step_cmd is stable while step_valid is high and step_ready is low.
  - On step_valid&step_ready: active_cmd=step_cmd, active=1, dwell counter loaded with DWELL_CYCLES-1, step_valid=0, go to DWELL.
  - Handshake-to-active latency is one clock.
- DWELL state:
  - Counter decrements each cycle; active stays high for exactly DWELL_CYCLES cycles.
  - At counter==0: active=0.
  - If step_idx==count-1: go to DONE and set done=1.
  - Otherwise: step_idx+1, go to FETCH.
- Command throughput: minimum of DWELL_CYCLES+2 clocks per command (FETCH + ISSUE + dwell) with step_ready held high.
- DONE state:
  - done=1, active=0.
  - exec: replay from index 0, same as exec in PROGRAM.
  - save: allowed, same rules as PROGRAM, and moves the state to PROGRAM with done cleared.
- busy=1 in FETCH, ISSUE and DWELL only.
- save or exec while busy: ignored, error pulse. No buffer or count change.
- clear in any state:
  - Next cycle: state=PROGRAM, count=0, step_idx=0.
  - step_valid=0, active=0, done=0.
  - This is the only case in which step_valid may drop without a handshake.
- full is combinational from count.
- step_idx never exceeds count-1; there is no wrap-around in playback.
- count saturates at DEPTH.
- error never asserts together with a state change caused by the same pulse.

Test Plan:
- Record and play (DWELL_CYCLES=4, step_ready tied high): save 00,01,11 → count=3. Exec → step_cmd 00,01,11 in order; active high 4 cycles each; done=1 after the last dwell; busy=0.
- Backpressure: during ISSUE, hold step_ready=0 for 10 cycles → step_valid stays high with step_cmd constant; active=0 until step_ready=1, then active=1 on the following cycle.
- Capacity: DEPTH=4, save 5 times → count=4, full=1, error pulses on the 5th save. Playback emits 4 commands, step_idx ends at 3.
- Empty and busy misuse:
  - exec with count=0 → error=1 for one cycle, state unchanged.
  - save during DWELL → error, count unchanged.
- Abort: clear during DWELL of step 1 → next cycle active=0, busy=0, count=0, step_valid=0. A subsequent exec → error.
- Async reset mid-ISSUE: assert rst between clock edges → all outputs at reset values immediately. After release, a save of 10 then exec plays back 10 only.
